shift_sequencer: RTL and testbench

- Controller that sequences an external 8-bit right-shift register: parallel load, N right shifts (logical or arithmetic), then result capture.
- Accepts one job at a time over a valid/ready handshake and drives the register's load_n, ShiftRight, ASR and reset_n controls.
- Reads the register's Q back, registers the result and flags completion.
- Sits between a front-end command source (switches, keys or an upstream FSM) and the shift-register datapath, all in one clock domain.

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_sequencer_if.sv | 31 +++
 rtl/shift_amt_counter.sv | 25 ++
 rtl/shift_sequencer.sv | 92 +++++++++
 tb/tb_shift_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift-register sequencer.
package shift_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_AMT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Job request channel into the sequencer.
// valid/ready: a job transfers on a rising edge where req_valid and req_ready are
// both high; the source holds req_data/req_amt/req_arith stable while req_valid waits.
interface shift_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amt;
    logic             req_arith;

    modport master (
        output req_valid,
        output req_data,
        output req_amt,
        output req_arith,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_amt,
        input  req_arith,
        output req_ready
    );
endinterface

// File: rtl/shift_amt_counter.sv
// Loadable down-counter for the remaining shift count; last flags one shift left.
module shift_amt_counter #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [AMT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);
    logic [AMT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == AMT_W'(1));
endmodule

// File: rtl/shift_sequencer.sv
// Sequences an external right-shift register: load, N shifts, capture Q.
// All register controls are decoded from the state register only.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    shift_sequencer_if.slave req,
    output logic             reg_load_n,
    output logic [WIDTH-1:0] reg_load_val,
    output logic             reg_shift,
    output logic             reg_asr,
    output logic             reg_reset_n,
    input  logic [WIDTH-1:0] reg_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output state_t           dbg_state
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] amt_q;
    logic             arith_q;
    logic [WIDTH-1:0] result_q;
    logic             result_valid_q;
    logic             accept;
    logic             cnt_last;
    logic [AMT_W-1:0] amt_clamped;

    assign accept      = (state_q == ST_IDLE) && req.req_valid;
    // Shifting further than WIDTH changes nothing, so the amount saturates there.
    assign amt_clamped = (req.req_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : req.req_amt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            data_q         <= '0;
            amt_q          <= '0;
            arith_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q         <= req.req_data;
                amt_q          <= amt_clamped;
                arith_q        <= req.req_arith;
                result_valid_q <= 1'b0;
            end
            if (state_q == ST_DONE) begin
                result_q       <= reg_q;
                result_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req.req_valid) state_d = ST_LOAD;
            ST_LOAD:  state_d = (amt_q != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    shift_amt_counter #(.AMT_W(AMT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == ST_LOAD),
        .load_val (amt_q),
        .dec      (state_q == ST_SHIFT),
        .last     (cnt_last)
    );

    assign req.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign reg_load_n    = (state_q != ST_LOAD);
    assign reg_load_val  = data_q;
    assign reg_shift     = (state_q == ST_SHIFT);
    assign reg_asr       = (state_q == ST_SHIFT) && arith_q;
    assign reg_reset_n   = ~reset;
    assign done          = (state_q == ST_DONE);
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: environment shift register, job-level model, directed jobs.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             reg_load_n, reg_shift, reg_asr, reg_reset_n;
    logic [WIDTH-1:0] reg_load_val, reg_q, result;
    logic             busy, done, result_valid;
    state_t           dbg_state;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) rif ();

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (rif),
        .reg_load_n   (reg_load_n),
        .reg_load_val (reg_load_val),
        .reg_shift    (reg_shift),
        .reg_asr      (reg_asr),
        .reg_reset_n  (reg_reset_n),
        .reg_q        (reg_q),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- environment: the external shift register
    logic [WIDTH-1:0] sr_q;
    always @(posedge clk) begin
        if (!reg_reset_n)     sr_q <= '0;
        else if (!reg_load_n) sr_q <= reg_load_val;
        else if (reg_shift)   sr_q <= reg_asr ? {sr_q[WIDTH-1], sr_q[WIDTH-1:1]} : {1'b0, sr_q[WIDTH-1:1]};
    end
    assign reg_q = sr_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- job-level model: m_k = cycles since accept (0 = idle)
    int               m_k = 0;
    int               m_amt = 0;
    logic             m_arith = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    logic [WIDTH-1:0] m_res = '0;
    logic             m_rv = 1'b0;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int amt, input logic arith);
        logic signed [WIDTH-1:0] s;
        s = d;
        if (arith) return WIDTH'(s >>> amt);
        return d >> amt;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_k    <= 0;
            m_data <= '0;
            m_res  <= '0;
            m_rv   <= 1'b0;
        end else if (m_k == 0) begin
            if (rif.req_valid) begin
                m_k     <= 1;
                m_data  <= rif.req_data;
                m_amt   <= (int'(rif.req_amt) > WIDTH) ? WIDTH : int'(rif.req_amt);
                m_arith <= rif.req_arith;
                m_rv    <= 1'b0;
            end
        end else if (m_k == m_amt + 2) begin
            m_k   <= 0;
            m_res <= ref_shift(m_data, m_amt, m_arith);
            m_rv  <= 1'b1;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_shift;
            e_shift = (m_k >= 2) && (m_k <= m_amt + 1);
            check("req_ready",    rif.req_ready, (m_k == 0));
            check("busy",         busy,          (m_k != 0));
            check("reg_load_n",   reg_load_n,    (m_k != 1));
            check("reg_shift",    reg_shift,     e_shift);
            check("reg_asr",      reg_asr,       e_shift && m_arith);
            check("reg_load_val", reg_load_val,  m_data);
            check("reg_reset_n",  reg_reset_n,   !reset);
            check("done",         done,          (m_k != 0) && (m_k == m_amt + 2));
            check("result",       result,        m_res);
            check("result_valid", result_valid,  m_rv);
        end
    end

    // ---------------- drivers
    task automatic wait_idle();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rif.req_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait_idle_timeout", seen, 1'b1);
    endtask

    task automatic run_job(input logic [7:0] data, input logic [3:0] amt, input logic arith,
                           input logic [7:0] exp_res, input int exp_lat, input int exp_shifts);
        int   lat, shifts;
        logic got;
        wait_idle();
        @(posedge clk); #2;
        rif.req_valid = 1'b1;
        rif.req_data  = data;
        rif.req_amt   = amt;
        rif.req_arith = arith;
        @(posedge clk); #2;
        rif.req_valid = 1'b0;
        lat = 1; shifts = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (reg_shift === 1'b1) shifts++;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        check("done_timeout", got, 1'b1);
        check("latency", lat, exp_lat);
        check("shift_cycles", shifts, exp_shifts);
        @(negedge clk);
        check("job_result", result, exp_res);
        check("job_result_valid", result_valid, 1'b1);
    endtask

    initial begin
        int d1, d2, cyc, dn;
        rif.req_valid = 1'b0;
        rif.req_data  = '0;
        rif.req_amt   = '0;
        rif.req_arith = 1'b0;
        reset = 1'b1;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_req_ready", rif.req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_load_n", reg_load_n, 1'b1);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_reg_reset_n", reg_reset_n, 1'b0);
        check("rst_reg_q", reg_q, 8'h00);
        @(posedge clk); #2;
        reset = 1'b0;

        run_job(8'hA5, 4'd3,  1'b0, 8'h14, 5,  3);
        run_job(8'h96, 4'd2,  1'b1, 8'hE5, 4,  2);
        run_job(8'h96, 4'd2,  1'b0, 8'h25, 4,  2);
        run_job(8'h3C, 4'd0,  1'b0, 8'h3C, 2,  0);
        run_job(8'h80, 4'd12, 1'b1, 8'hFF, 10, 8);
        run_job(8'h80, 4'd12, 1'b0, 8'h00, 10, 8);

        // req_valid held high: two amt=1 jobs, done pulses amt+3 cycles apart
        wait_idle();
        @(posedge clk); #2;
        rif.req_valid = 1'b1;
        rif.req_data  = 8'h81;
        rif.req_amt   = 4'd1;
        rif.req_arith = 1'b0;
        d1 = -1; d2 = -1; dn = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dn++;
                if (dn == 1) d1 = cyc;
                else begin
                    d2 = cyc;
                    rif.req_valid = 1'b0;
                    break;
                end
            end
        end
        rif.req_valid = 1'b0;
        check("b2b_two_dones", dn, 2);
        check("b2b_spacing", d2 - d1, 4);
        @(negedge clk);
        check("b2b_result", result, 8'h40);

        // reset during the second SHIFT cycle of an amt=5 job
        wait_idle();
        @(posedge clk); #2;
        rif.req_valid = 1'b1;
        rif.req_data  = 8'hF0;
        rif.req_amt   = 4'd5;
        rif.req_arith = 1'b1;
        @(posedge clk); #2;
        rif.req_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        rif.req_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_still_shifting", reg_shift, 1'b1);
        check("mid_rst_reg_reset_n", reg_reset_n, 1'b0);
        @(posedge clk); #2;
        reset = 1'b0;
        rif.req_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_result_valid", result_valid, 1'b0);
        check("abort_reg_q", reg_q, 8'h00);
        check("abort_state", dbg_state, ST_IDLE);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("abort_no_done", dn, 0);

        run_job(8'h7F, 4'd4, 1'b1, 8'h07, 6, 4);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
